pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl_pkg.sv | 24 ++
 rtl/pattern_scan_ctrl_window_match.sv | 35 +++
 rtl/pattern_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the pattern-count controller: FSM states and the
// fixed data-memory map (message bytes 0..31, pattern at 32, results 33..35).
package pattern_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_PAT = 3'd1,
    SCAN     = 3'd2,
    WR_CTB   = 3'd3,
    WR_CTO   = 3'd4,
    WR_CTS   = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [7:0] PAT_ADDR = 8'd32;
  localparam logic [7:0] CTB_ADDR = 8'd33;
  localparam logic [7:0] CTO_ADDR = 8'd34;
  localparam logic [7:0] CTS_ADDR = 8'd35;
  localparam int         MSG_LEN  = 32;

  // Byte index of the last message byte; the 5-bit index wraps to 0 after it.
  localparam logic [4:0] LAST_INDEX = 5'(MSG_LEN - 1);

endpackage

// File: rtl/pattern_scan_ctrl_window_match.sv
// Combinational matcher for one scanned byte. The 12-bit window is
// {previous_byte[3:0], current_byte[7:0]}. In-byte matches look only at the
// four slices of the current byte; stream matches also include the four
// windows that straddle the previous byte, except for the first byte which has
// no predecessor in the bit stream.
module pattern_window_match
  import pattern_scan_ctrl_pkg::*;
(
  input  logic [11:0] i_window,
  input  logic [4:0]  i_pattern,
  input  logic        i_first,
  output logic [2:0]  o_in_byte_cnt,
  output logic        o_any_in_byte,
  output logic [3:0]  o_stream_cnt
);

  // Count pattern hits at every 5-bit offset k of the window (k = 0..7).
  always_comb begin
    o_in_byte_cnt = 3'd0;
    o_stream_cnt  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (i_window[k +: 5] == i_pattern) begin
        if (k < 4) begin
          o_in_byte_cnt = o_in_byte_cnt + 3'd1;
        end
        if ((k < 4) || !i_first) begin
          o_stream_cnt = o_stream_cnt + 4'd1;
        end
      end
    end
  end

  assign o_any_in_byte = (o_in_byte_cnt != 3'd0);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern-count job sequencer: loads a 5-bit pattern from address 32, scans
// message bytes 0..31 one per cycle, then writes ctb/cto/cts to 33/34/35.
// Memory interface: mem_rd_data is combinational from mem_addr; memory
// captures mem_wr_data at mem_addr on a rising edge where mem_wr_en=1.
// Start handshake: req is level-sampled in IDLE; from DONE a restart needs req
// seen low in DONE and then high. req is ignored while a job is running.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_pattern;
  logic [4:0] r_index;
  logic [3:0] r_prev;
  logic [7:0] r_ctb;
  logic [7:0] r_cto;
  logic [7:0] r_cts;
  logic       r_armed;

  logic        w_wr_en;
  logic        w_first;
  logic [11:0] w_window;
  logic [2:0]  w_in_cnt;
  logic        w_any;
  logic [3:0]  w_stream_cnt;

  assign w_first  = (r_index == 5'd0);
  assign w_window = {r_prev, mem_rd_data};

  pattern_window_match u_match (
    .i_window      (w_window),
    .i_pattern     (r_pattern),
    .i_first       (w_first),
    .o_in_byte_cnt (w_in_cnt),
    .o_any_in_byte (w_any),
    .o_stream_cnt  (w_stream_cnt)
  );

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs per state.
  always_comb begin
    w_next      = r_state;
    done        = 1'b0;
    mem_addr    = 8'd0;
    w_wr_en     = 1'b0;
    mem_wr_data = 8'd0;
    case (r_state)
      IDLE: begin
        if (req) w_next = LOAD_PAT;
      end
      LOAD_PAT: begin
        mem_addr = PAT_ADDR;
        w_next   = SCAN;
      end
      SCAN: begin
        mem_addr = {3'b000, r_index};
        if (r_index == LAST_INDEX) w_next = WR_CTB;
      end
      WR_CTB: begin
        w_wr_en     = 1'b1;
        mem_addr    = CTB_ADDR;
        mem_wr_data = r_ctb;
        w_next      = WR_CTO;
      end
      WR_CTO: begin
        w_wr_en     = 1'b1;
        mem_addr    = CTO_ADDR;
        mem_wr_data = r_cto;
        w_next      = WR_CTS;
      end
      WR_CTS: begin
        w_wr_en     = 1'b1;
        mem_addr    = CTS_ADDR;
        mem_wr_data = r_cts;
        w_next      = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (r_armed && req) w_next = LOAD_PAT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A reset arriving during a write cycle suppresses that write, so the
  // result locations are never touched at or after the reset edge.
  assign mem_wr_en = w_wr_en & ~reset;

  // Datapath: pattern capture, per-byte counter accumulation, restart arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= 5'd0;
      r_index   <= 5'd0;
      r_prev    <= 4'd0;
      r_ctb     <= 8'd0;
      r_cto     <= 8'd0;
      r_cts     <= 8'd0;
      r_armed   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_PAT: begin
          r_pattern <= mem_rd_data[4:0];
          r_index   <= 5'd0;
          r_prev    <= 4'd0;
          r_ctb     <= 8'd0;
          r_cto     <= 8'd0;
          r_cts     <= 8'd0;
        end
        SCAN: begin
          r_ctb   <= r_ctb + {5'd0, w_in_cnt};
          r_cto   <= r_cto + {7'd0, w_any};
          r_cts   <= r_cts + {4'd0, w_stream_cnt};
          r_prev  <= mem_rd_data[3:0];
          r_index <= r_index + 5'd1;
        end
        default: begin
        end
      endcase
      // Armed only after req has been observed low while sitting in DONE.
      r_armed <= (r_state == DONE) && (w_next == DONE) && (r_armed || !req);
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl. A single process drives stimulus,
// steps a phase-level reference model, samples the DUT at the falling edge and
// commits memory writes at the rising edge. Expected result writes come from
// a bit-stream reference computation and are queued in exp_q.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  // Message image (0..31) and pattern (32); results land in res[33..35].
  logic [7:0] msg [0:63];
  logic [7:0] res [33:35];
  int         wr_count;

  int checks;
  int errors;

  // Reference model state: m_t is the number of edges since the job was
  // accepted (0 = idle, 1 = pattern fetch, 2..33 = bytes, 34..36 = writes,
  // 37 = done).
  int          m_t;
  bit          m_armed;
  logic [15:0] exp_q [$];

  // Inputs as seen by the DUT at the upcoming edge, sampled mid-cycle.
  logic       s_req;
  logic       s_rst;
  logic       s_we;
  logic [7:0] s_addr;
  logic [7:0] s_data;

  assign mem_rd_data = (mem_addr < 8'd33) ? msg[mem_addr[5:0]] : 8'h00;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts computed straight from the definitions: slices of each byte, and
  // every 5-bit window of the 256-bit big-endian bit stream.
  function automatic void ref_counts(output logic [7:0] ctb, output logic [7:0] cto,
                                     output logic [7:0] cts);
    logic [255:0] s;
    logic [4:0]   pat;
    int           nb;
    pat = msg[32][4:0];
    ctb = 8'd0;
    cto = 8'd0;
    cts = 8'd0;
    s   = '0;
    for (int i = 0; i < 32; i++) begin
      s[255 - 8*i -: 8] = msg[i];
      nb = 0;
      for (int j = 0; j < 4; j++) begin
        if (msg[i][j +: 5] == pat) nb++;
      end
      ctb = ctb + 8'(nb);
      if (nb > 0) cto = cto + 8'd1;
    end
    for (int p = 0; p < 252; p++) begin
      if (s[255 - p -: 5] == pat) cts = cts + 8'd1;
    end
  endfunction

  task automatic model_accept();
    logic [7:0] a, b, c;
    ref_counts(a, b, c);
    m_t     = 1;
    m_armed = 1'b0;
    exp_q.delete();
    exp_q.push_back({8'd33, a});
    exp_q.push_back({8'd34, b});
    exp_q.push_back({8'd35, c});
  endtask

  task automatic model_step();
    if (s_rst) begin
      m_t     = 0;
      m_armed = 1'b0;
      exp_q.delete();
    end else if (m_t == 0) begin
      if (s_req) model_accept();
    end else if (m_t < 37) begin
      m_t++;
    end else if (m_armed && s_req) begin
      model_accept();
    end else if (!s_req) begin
      m_armed = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic       exp_we;
    logic [7:0] exp_addr;
    logic [15:0] e;
    exp_we = !s_rst && (m_t >= 34) && (m_t <= 36);
    if (m_t == 1)                     exp_addr = 8'd32;
    else if (m_t >= 2 && m_t <= 33)   exp_addr = 8'(m_t - 2);
    else if (m_t >= 34 && m_t <= 36)  exp_addr = 8'(33 + m_t - 34);
    else                              exp_addr = 8'd0;
    chk("cyc_wr_en", mem_wr_en, exp_we);
    if (!s_rst) begin
      chk("cyc_done", done, (m_t == 37));
      chk("cyc_addr", mem_addr, exp_addr);
    end
    if (mem_wr_en) begin
      chk("wr_addr_range", (mem_addr >= 8'd33) && (mem_addr <= 8'd35), 1'b1);
    end
    if (exp_we) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("wr_beat", {mem_addr, mem_wr_data}, e);
    end
  endtask

  // One clock: compare mid-cycle, commit write and model at the rising edge,
  // return 1 time unit after the edge so new inputs are driven off-edge.
  task automatic tick();
    @(negedge clk);
    s_req  = req;
    s_rst  = reset;
    compare_outputs();
    s_we   = mem_wr_en;
    s_addr = mem_addr;
    s_data = mem_wr_data;
    @(posedge clk);
    if (s_we) begin
      wr_count++;
      if (s_addr >= 8'd33 && s_addr <= 8'd35) res[s_addr] = s_data;
    end
    model_step();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_msg(input logic [7:0] pat, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] rest);
    msg[32] = pat;
    msg[0]  = b0;
    msg[1]  = b1;
    for (int i = 2; i < 32; i++) msg[i] = rest;
  endtask

  // Leaves req low for one edge (arms a restart from DONE), accepts the job,
  // then waits for done. lat is the number of edges after acceptance.
  task automatic run_job(input bit hold, input bit rand_req, output int lat);
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    lat = 0;
    do begin
      req = hold ? 1'b1 : (rand_req ? 1'($urandom_range(0, 1)) : 1'b0);
      tick();
      lat++;
    end while (!done && lat < 100);
    chk("done_within_budget", (lat < 100), 1'b1);
    if (!hold) req = 1'b0;
  endtask

  task automatic directed(input string name, input logic [7:0] pat, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] rest,
                          input logic [7:0] e_ctb, input logic [7:0] e_cto,
                          input logic [7:0] e_cts);
    int lat;
    int w0;
    logic [7:0] a, b, c;
    load_msg(pat, b0, b1, rest);
    ref_counts(a, b, c);
    chk({name, "_model_ctb"}, a, e_ctb);
    chk({name, "_model_cto"}, b, e_cto);
    chk({name, "_model_cts"}, c, e_cts);
    w0 = wr_count;
    run_job(1'b0, 1'b0, lat);
    chk({name, "_latency"}, lat, 36);
    chk({name, "_writes"}, wr_count - w0, 3);
    chk({name, "_ctb"}, res[33], e_ctb);
    chk({name, "_cto"}, res[34], e_cto);
    chk({name, "_cts"}, res[35], e_cts);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int w0;
    logic [7:0] a, b, c;
    logic [7:0] sv_ctb, sv_cto, sv_cts;
    logic [7:0] p;
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    m_t      = 0;
    m_armed  = 1'b0;
    reset    = 1'b1;
    req      = 1'b0;
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;

    // Reset, with req high to show reset takes precedence.
    req = 1'b1;
    repeat (3) tick();
    req   = 1'b0;
    reset = 1'b0;
    chk("reset_done", done, 1'b0);
    chk("reset_addr", mem_addr, 8'd0);
    chk("reset_wr_en", mem_wr_en, 1'b0);
    chk("reset_wr_data", mem_wr_data, 8'd0);
    repeat (2) tick();

    // Directed jobs; expectations hand-derived from the slice/stream rules.
    directed("zeros",   8'h00, 8'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
    directed("alt55",   8'hF5, 8'h55, 8'h55, 8'h55, 8'd64,  8'd32, 8'd126);
    directed("nomatch", 8'h1F, 8'h00, 8'h00, 8'h00, 8'd0,   8'd0,  8'd0);
    directed("b0_0e",   8'h07, 8'h0E, 8'h00, 8'h00, 8'd1,   8'd1,  8'd1);
    directed("b1_07",   8'h07, 8'h00, 8'h07, 8'h00, 8'd1,   8'd1,  8'd1);
    directed("cross",   8'h07, 8'h01, 8'hC0, 8'h00, 8'd0,   8'd0,  8'd1);

    // Abort during the scan at byte index 10: no writes may follow.
    load_msg(8'h0A, 8'h5A, 8'hA5, 8'h3C);
    sv_ctb = res[33];
    sv_cto = res[34];
    sv_cts = res[35];
    w0 = wr_count;
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (11) tick();
    chk("abort_scan_index", mem_addr, 8'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_done", done, 1'b0);
    chk("abort_addr", mem_addr, 8'd0);
    chk("abort_wr_en", mem_wr_en, 1'b0);
    repeat (40) tick();
    chk("abort_no_writes", wr_count - w0, 0);
    chk("abort_ctb_kept", res[33], sv_ctb);
    chk("abort_cts_kept", res[35], sv_cts);
    // Fresh job from IDLE after the abort.
    ref_counts(a, b, c);
    w0 = wr_count;
    run_job(1'b0, 1'b0, lat);
    chk("after_abort_latency", lat, 36);
    chk("after_abort_writes", wr_count - w0, 3);
    chk("after_abort_ctb", res[33], a);
    chk("after_abort_cto", res[34], b);
    chk("after_abort_cts", res[35], c);

    // req held high through DONE: no restart until it drops and rises again.
    load_msg(8'h13, 8'h93, 8'h26, 8'h4D);
    run_job(1'b1, 1'b0, lat);
    chk("hold_latency", lat, 36);
    sv_ctb = res[33];
    sv_cto = res[34];
    sv_cts = res[35];
    w0 = wr_count;
    repeat (20) tick();
    chk("hold_done_stays", done, 1'b1);
    chk("hold_no_restart", wr_count - w0, 0);
    run_job(1'b0, 1'b0, lat);
    chk("rerun_latency", lat, 36);
    chk("rerun_writes", wr_count - w0, 3);
    chk("rerun_ctb", res[33], sv_ctb);
    chk("rerun_cto", res[34], sv_cto);
    chk("rerun_cts", res[35], sv_cts);

    // Randomized jobs with req toggling while busy; bytes biased to contain
    // the pattern so every counter sees non-trivial values.
    for (int n = 0; n < 8; n++) begin
      p = 8'($urandom_range(0, 255));
      msg[32] = p;
      for (int i = 0; i < 32; i++) begin
        case ($urandom_range(0, 2))
          0: msg[i] = 8'($urandom_range(0, 255));
          1: msg[i] = {3'($urandom_range(0, 7)), p[4:0]};
          default: msg[i] = {p[3:0], 4'($urandom_range(0, 15))};
        endcase
      end
      ref_counts(a, b, c);
      w0 = wr_count;
      run_job(1'b0, 1'b1, lat);
      chk("rand_latency", lat, 36);
      chk("rand_writes", wr_count - w0, 3);
      chk("rand_ctb", res[33], a);
      chk("rand_cto", res[34], b);
      chk("rand_cts", res[35], c);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
